i2c_master_ctrl: RTL



---
 rtl/i2c_pkg.sv | 12 +
 rtl/i2c_quarter_timer.sv | 35 +++
 rtl/i2c_master_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access master.
package i2c_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR, ST_ACK1, ST_REG, ST_ACK2, ST_DATA, ST_ACK3, ST_STOP
  } state_t;

  localparam logic       RW_READ          = 1'b1;
  localparam logic       RW_WRITE         = 1'b0;
  localparam logic [6:0] SLAVE_ID_DEFAULT = 7'h05;

  typedef logic [1:0] qidx_t;
endpackage

// File: rtl/i2c_quarter_timer.sv
// Divides CLK into quarter-bit slots: q index, quarter-start strobe and slot-end flag.
module i2c_quarter_timer
  import i2c_pkg::*;
#(
  parameter int Q_DIV = 31
) (
  input  logic  CLK,
  input  logic  Reset,
  input  logic  clr,
  output qidx_t q,
  output logic  qstart,
  output logic  slot_end
);
  localparam logic [7:0] QMAX = 8'(Q_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
      q   <= '0;
    end else if (clr) begin
      cnt <= '0;
      q   <= '0;
    end else if (cnt == QMAX) begin
      cnt <= '0;
      q   <= q + 2'd1;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign qstart   = (cnt == 8'd0);
  assign slot_end = (q == 2'd3) && (cnt == QMAX);
endmodule

// File: rtl/i2c_master_ctrl.sv
// I2C master sequencer: START, {ID,RW}, REG, DATA, STOP with ACK checks per byte.
// Define I2C_RETRY_EN to retry an address NACK up to MAX_RETRY times.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int Q_DIV     = 31,
  parameter int MAX_RETRY = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] dev_id,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic       iSDA,
  output logic       SCL,
  output logic       oSDA_oe,
  output logic       busy,
  output logic       done,
  output logic       nack_err,
  output logic [7:0] rdata
);
  state_t     state, nxt;
  qidx_t      q;
  logic       qstart, slot_end, q3_first;
  logic       rw_q, ack_s;
  logic [6:0] id_q;
  logic [7:0] reg_q, wd_q, rx_sh, tx_byte;
  logic [2:0] bitcnt;
  logic       byte_st, ack_st, rd_data_st, nack_hit;
  logic       retry_pend, retry_take;

  i2c_quarter_timer #(.Q_DIV(Q_DIV)) u_qt (
    .CLK      (CLK),
    .Reset    (Reset),
    .clr      (state == ST_IDLE),
    .q        (q),
    .qstart   (qstart),
    .slot_end (slot_end)
  );

  assign q3_first   = qstart && (q == 2'd3);
  assign byte_st    = (state == ST_ADDR) || (state == ST_REG) || (state == ST_DATA);
  assign ack_st     = (state == ST_ACK1) || (state == ST_ACK2) || (state == ST_ACK3);
  assign rd_data_st = (state == ST_DATA) && (rw_q == RW_READ);
  // ACK3 on a read is the master's own NACK, not a slave error
  assign nack_hit   = slot_end && ack_s &&
                      ((state == ST_ACK1) || (state == ST_ACK2) ||
                       ((state == ST_ACK3) && (rw_q == RW_WRITE)));

  always_comb begin
    case (state)
      ST_ADDR: tx_byte = {id_q, rw_q};
      ST_REG:  tx_byte = reg_q;
      default: tx_byte = wd_q;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt     = state;
    SCL     = 1'b1;
    oSDA_oe = 1'b0;
    case (state)
      ST_IDLE:  if (req) nxt = ST_START;
      ST_START: begin
        oSDA_oe = q[1];
        if (slot_end) nxt = ST_ADDR;
      end
      ST_ADDR, ST_REG, ST_DATA: begin
        SCL     = q[1];
        oSDA_oe = rd_data_st ? 1'b0 : ~tx_byte[3'd7 - bitcnt];
        if (slot_end && bitcnt == 3'd7)
          nxt = (state == ST_ADDR) ? ST_ACK1 : (state == ST_REG) ? ST_ACK2 : ST_ACK3;
      end
      ST_ACK1: begin
        SCL = q[1];
        if (slot_end) nxt = ack_s ? ST_STOP : ST_REG;
      end
      ST_ACK2: begin
        SCL = q[1];
        if (slot_end) nxt = ack_s ? ST_STOP : ST_DATA;
      end
      ST_ACK3: begin
        SCL = q[1];
        if (slot_end) nxt = ST_STOP;
      end
      ST_STOP: begin
        SCL     = q[1];
        oSDA_oe = (q != 2'd3);
        if (slot_end) nxt = retry_pend ? ST_START : ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rw_q     <= 1'b0;
      id_q     <= '0;
      reg_q    <= '0;
      wd_q     <= '0;
      rx_sh    <= '0;
      bitcnt   <= '0;
      ack_s    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack_err <= 1'b0;
      rdata    <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE && req) begin
        rw_q     <= rw;
        id_q     <= dev_id;
        reg_q    <= reg_addr;
        wd_q     <= wdata;
        bitcnt   <= '0;
        busy     <= 1'b1;
        nack_err <= 1'b0;
      end
      if (q3_first && ack_st)     ack_s <= iSDA;
      if (q3_first && rd_data_st) rx_sh <= {rx_sh[6:0], iSDA};
      // 3-bit counter wraps to 0 after each byte
      if (slot_end && byte_st)    bitcnt <= bitcnt + 3'd1;
      if (nack_hit && !retry_take) nack_err <= 1'b1;
      if (state == ST_STOP && slot_end && !retry_pend) begin
        busy <= 1'b0;
        done <= 1'b1;
        if (rw_q == RW_READ && !nack_err) rdata <= rx_sh;
      end
    end
  end

`ifdef I2C_RETRY_EN
  logic [7:0] retry_cnt;

  assign retry_take = slot_end && ack_s && (state == ST_ACK1) &&
                      (retry_cnt < 8'(MAX_RETRY));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else if (state == ST_IDLE && req) begin
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else if (retry_take) begin
      retry_cnt  <= retry_cnt + 8'd1;
      retry_pend <= 1'b1;
    end else if (state == ST_STOP && slot_end) begin
      retry_pend <= 1'b0;
    end
  end
`else
  assign retry_take = 1'b0;
  assign retry_pend = 1'b0;
`endif
endmodule
